// File: rtl/immgen_pipe.sv
// Registered RV32I/RV64I immediate generator with pc+imm target and a 2-entry skid buffer.
// Optional CSR zimm decode for sel 7 is built only when IMMGEN_ZIMM_EN is defined.
module immgen_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_sel,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_target,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_bad_sel
);

  localparam logic [2:0] SEL_NONE  = 3'd0;
  localparam logic [2:0] SEL_I     = 3'd1;
  localparam logic [2:0] SEL_S     = 3'd2;
  localparam logic [2:0] SEL_B     = 3'd3;
  localparam logic [2:0] SEL_U     = 3'd4;
  localparam logic [2:0] SEL_J     = 3'd5;
  localparam logic [2:0] SEL_SHAMT = 3'd6;
  localparam logic [2:0] SEL_ZIMM  = 3'd7;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("immgen_pipe: XLEN must be 32 or 64");
  end

  // Widths work out for both XLEN values: 33+31 or 1+31 bits.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-31){v[31]}}, v[30:0]};
  endfunction

  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_target;
  logic            dec_bad;
  logic            unused_bits;

  assign unused_bits = ^in_instr[6:0];

  always_comb begin
    dec_imm = '0;
    dec_bad = 1'b0;
    case (in_sel)
      SEL_NONE: dec_imm = '0;
      SEL_I:    dec_imm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
      SEL_S:    dec_imm = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
      SEL_B:    dec_imm = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                  in_instr[30:25], in_instr[11:8], 1'b0});
      SEL_U:    dec_imm = sext32({in_instr[31:12], 12'b0});
      SEL_J:    dec_imm = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                  in_instr[20], in_instr[30:21], 1'b0});
      SEL_SHAMT: begin
        if (XLEN == 64) dec_imm = XLEN'(in_instr[25:20]);
        else            dec_imm = XLEN'(in_instr[24:20]);
      end
`ifdef IMMGEN_ZIMM_EN
      SEL_ZIMM: dec_imm = XLEN'(in_instr[19:15]);
`else
      SEL_ZIMM: dec_bad = 1'b1;
`endif
      default:  dec_imm = '0;
    endcase
  end

  assign dec_target = in_pc + dec_imm;

  logic             in_ready_reg;
  logic             prim_valid_reg, skid_valid_reg;
  logic [XLEN-1:0]  prim_imm_reg, prim_target_reg, skid_imm_reg, skid_target_reg;
  logic [TAG_W-1:0] prim_tag_reg, skid_tag_reg;
  logic             prim_bad_reg, skid_bad_reg;

  logic accept, drain;
  logic prim_valid_next, skid_valid_next;
  logic load_prim_in, load_prim_skid, load_skid;

  assign accept = in_valid && in_ready_reg && !flush;
  assign drain  = prim_valid_reg && out_ready;

  // in_ready mirrors !skid_valid, so an accept never coincides with a full skid.
  always_comb begin
    prim_valid_next = prim_valid_reg;
    skid_valid_next = skid_valid_reg;
    load_prim_in    = 1'b0;
    load_prim_skid  = 1'b0;
    load_skid       = 1'b0;
    if (flush) begin
      prim_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (skid_valid_reg && drain) begin
      load_prim_skid  = 1'b1;
      skid_valid_next = 1'b0;
    end else if (prim_valid_reg && !drain) begin
      if (accept) begin
        load_skid       = 1'b1;
        skid_valid_next = 1'b1;
      end
    end else begin
      load_prim_in    = accept;
      prim_valid_next = accept;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_reg    <= 1'b0;
      prim_valid_reg  <= 1'b0;
      skid_valid_reg  <= 1'b0;
      prim_imm_reg    <= '0;
      prim_target_reg <= '0;
      prim_tag_reg    <= '0;
      prim_bad_reg    <= 1'b0;
      skid_imm_reg    <= '0;
      skid_target_reg <= '0;
      skid_tag_reg    <= '0;
      skid_bad_reg    <= 1'b0;
    end else begin
      in_ready_reg   <= !skid_valid_next;
      prim_valid_reg <= prim_valid_next;
      skid_valid_reg <= skid_valid_next;
      if (load_prim_in) begin
        prim_imm_reg    <= dec_imm;
        prim_target_reg <= dec_target;
        prim_tag_reg    <= in_tag;
        prim_bad_reg    <= dec_bad;
      end else if (load_prim_skid) begin
        prim_imm_reg    <= skid_imm_reg;
        prim_target_reg <= skid_target_reg;
        prim_tag_reg    <= skid_tag_reg;
        prim_bad_reg    <= skid_bad_reg;
      end
      if (load_skid) begin
        skid_imm_reg    <= dec_imm;
        skid_target_reg <= dec_target;
        skid_tag_reg    <= in_tag;
        skid_bad_reg    <= dec_bad;
      end
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = prim_valid_reg;
  assign out_imm     = prim_imm_reg;
  assign out_target  = prim_target_reg;
  assign out_tag     = prim_tag_reg;
  assign out_bad_sel = prim_bad_reg;

endmodule

// File: tb/tb_immgen_pipe.sv
// Directed bench for immgen_pipe (XLEN=64): formats, wrap, back-pressure, flush, reset.
module tb_immgen_pipe;
  localparam int XLEN  = 64;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, out_ready;
  logic             in_ready, out_valid, out_bad_sel;
  logic [31:0]      in_instr;
  logic [2:0]       in_sel;
  logic [XLEN-1:0]  in_pc, out_imm, out_target;
  logic [TAG_W-1:0] in_tag, out_tag;

  int checks = 0;
  int errors = 0;

  immgen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_sel(in_sel),
    .in_pc(in_pc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_target(out_target), .out_tag(out_tag), .out_bad_sel(out_bad_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic drive_in(input logic [31:0] instr, input logic [2:0] sel,
                          input logic [63:0] pc, input logic [7:0] tag);
    in_valid = 1'b1;
    in_instr = instr;
    in_sel   = sel;
    in_pc    = pc;
    in_tag   = tag;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_sel = '0; in_pc = '0; in_tag = '0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_imm !== '0) begin errors++; $display("FAIL rst_imm: got %h want 0", out_imm); end
    checks++; if (out_target !== '0) begin errors++; $display("FAIL rst_target: got %h want 0", out_target); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL rst_tag: got %h want 0", out_tag); end
    checks++; if (out_bad_sel !== 1'b0) begin errors++; $display("FAIL rst_bad: got %b want 0", out_bad_sel); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_release_valid: got %b want 0", out_valid); end
    $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
  endtask

  task automatic test_formats;
    logic [31:0] v_instr [11];
    logic [2:0]  v_sel   [11];
    logic [63:0] v_pc    [11];
    logic [63:0] v_imm   [11];
    logic [63:0] v_tgt   [11];
    logic        v_bad   [11];
    v_instr[0]  = 32'hFFF00093; v_sel[0]  = 3'd1; v_pc[0]  = 64'h1000;
    v_imm[0]    = 64'hFFFF_FFFF_FFFF_FFFF; v_tgt[0]  = 64'h0FFF;        v_bad[0]  = 1'b0;
    v_instr[1]  = 32'hFE000EE3; v_sel[1]  = 3'd3; v_pc[1]  = 64'h8000_0010;
    v_imm[1]    = 64'hFFFF_FFFF_FFFF_FFFC; v_tgt[1]  = 64'h8000_000C;   v_bad[1]  = 1'b0;
    v_instr[2]  = 32'h800000B7; v_sel[2]  = 3'd4; v_pc[2]  = 64'h0;
    v_imm[2]    = 64'hFFFF_FFFF_8000_0000; v_tgt[2]  = 64'hFFFF_FFFF_8000_0000; v_bad[2] = 1'b0;
    v_instr[3]  = 32'h123450B7; v_sel[3]  = 3'd4; v_pc[3]  = 64'h10;
    v_imm[3]    = 64'h1234_5000;           v_tgt[3]  = 64'h1234_5010;   v_bad[3]  = 1'b0;
    v_instr[4]  = 32'hFE112C23; v_sel[4]  = 3'd2; v_pc[4]  = 64'h100;
    v_imm[4]    = 64'hFFFF_FFFF_FFFF_FFF8; v_tgt[4]  = 64'hF8;          v_bad[4]  = 1'b0;
    v_instr[5]  = 32'h0010006F; v_sel[5]  = 3'd5; v_pc[5]  = 64'h2000;
    v_imm[5]    = 64'h800;                 v_tgt[5]  = 64'h2800;        v_bad[5]  = 1'b0;
    v_instr[6]  = 32'h8000006F; v_sel[6]  = 3'd5; v_pc[6]  = 64'h10_0000;
    v_imm[6]    = 64'hFFFF_FFFF_FFF0_0000; v_tgt[6]  = 64'h0;           v_bad[6]  = 1'b0;
    v_instr[7]  = 32'h83F00013; v_sel[7]  = 3'd6; v_pc[7]  = 64'h0;
    v_imm[7]    = 64'h3F;                  v_tgt[7]  = 64'h3F;          v_bad[7]  = 1'b0;
    v_instr[8]  = 32'hFFFFFFFF; v_sel[8]  = 3'd0; v_pc[8]  = 64'h55;
    v_imm[8]    = 64'h0;                   v_tgt[8]  = 64'h55;          v_bad[8]  = 1'b0;
    v_instr[9]  = 32'h800F8073; v_sel[9]  = 3'd7; v_pc[9]  = 64'h40;
`ifdef IMMGEN_ZIMM_EN
    v_imm[9]    = 64'h1F;                  v_tgt[9]  = 64'h5F;          v_bad[9]  = 1'b0;
`else
    v_imm[9]    = 64'h0;                   v_tgt[9]  = 64'h40;          v_bad[9]  = 1'b1;
`endif
    v_instr[10] = 32'h00800093; v_sel[10] = 3'd1; v_pc[10] = 64'hFFFF_FFFF_FFFF_FFFC;
    v_imm[10]   = 64'h8;                   v_tgt[10] = 64'h4;           v_bad[10] = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive_in(v_instr[i], v_sel[i], v_pc[i], 8'h30 + 8'(i));
      @(negedge clk);
      in_valid = 1'b0;
      $display("fmt %0d: instr=%h sel=%0d imm=%h target=%h tag=%h bad=%b",
               i, v_instr[i], v_sel[i], out_imm, out_target, out_tag, out_bad_sel);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fmt%0d_valid: got %b want 1", i, out_valid); end
      checks++; if (out_imm !== v_imm[i]) begin errors++; $display("FAIL fmt%0d_imm: got %h want %h", i, out_imm, v_imm[i]); end
      checks++; if (out_target !== v_tgt[i]) begin errors++; $display("FAIL fmt%0d_target: got %h want %h", i, out_target, v_tgt[i]); end
      checks++; if (out_tag !== 8'h30 + 8'(i)) begin errors++; $display("FAIL fmt%0d_tag: got %h want %h", i, out_tag, 8'h30 + 8'(i)); end
      checks++; if (out_bad_sel !== v_bad[i]) begin errors++; $display("FAIL fmt%0d_bad: got %b want %b", i, out_bad_sel, v_bad[i]); end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fmt_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    @(negedge clk);
    drive_in({4'h0, 8'h01, 20'h00013}, 3'd1, 64'h0, 8'h01);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b want 1", in_ready); end
    checks++; if (out_tag !== 8'h01 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_first: got tag %h valid %b want 01/1", out_tag, out_valid); end
    drive_in({4'h0, 8'h02, 20'h00013}, 3'd1, 64'h0, 8'h02);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
    drive_in({4'h0, 8'h03, 20'h00013}, 3'd1, 64'h0, 8'h03);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready: got %b want 0", in_ready); end
    checks++; if (out_tag !== 8'h01 || out_imm !== 64'h1) begin errors++; $display("FAIL bp_stable: got tag %h imm %h want 01/1", out_tag, out_imm); end
    out_ready = 1'b1;
    @(negedge clk);
    $display("bp out: tag=%h imm=%h", out_tag, out_imm);
    checks++; if (out_tag !== 8'h02 || out_imm !== 64'h2 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_second: got tag %h imm %h want 02/2", out_tag, out_imm); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_reopen: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    $display("bp out: tag=%h imm=%h", out_tag, out_imm);
    checks++; if (out_tag !== 8'h03 || out_imm !== 64'h3 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_third: got tag %h imm %h want 03/3", out_tag, out_imm); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got valid %b want 0", out_valid); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    @(negedge clk); drive_in(32'h00100093, 3'd1, 64'h0, 8'h11);
    @(negedge clk); drive_in(32'h00200093, 3'd1, 64'h0, 8'h12);
    @(negedge clk); drive_in(32'h00300093, 3'd1, 64'h0, 8'h13); flush = 1'b1;
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush2_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush2_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush2_stays_empty: got %b want 0", out_valid); end
    $display("flush full: out_valid=%b in_ready=%b", out_valid, in_ready);
    out_ready = 1'b0;
    @(negedge clk); drive_in(32'h00400093, 3'd1, 64'h0, 8'h14);
    @(negedge clk); drive_in(32'h00500093, 3'd1, 64'h0, 8'h15); flush = 1'b1;
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush1_valid: got %b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush1_ignored_input: got %b want 0", out_valid); end
    checks++; if (out_tag !== 8'h14) begin errors++; $display("FAIL flush1_hold_tag: got %h want 14", out_tag); end
    $display("flush one: out_valid=%b out_tag=%h", out_valid, out_tag);
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        $display("b2b out: tag=%h", out_tag);
        checks++; if (out_valid !== 1'b1 || out_tag !== 8'h20 + 8'(i - 1)) begin errors++; $display("FAIL b2b%0d: got valid %b tag %h want 1/%h", i, out_valid, out_tag, 8'h20 + 8'(i - 1)); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_ready: got %b want 1", i, in_ready); end
      end
      if (i < 5) drive_in(32'h00000013, 3'd0, 64'h0, 8'h20 + 8'(i));
      else       in_valid = 1'b0;
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    @(negedge clk); drive_in(32'h00100093, 3'd1, 64'h0, 8'h40);
    @(negedge clk); drive_in(32'h00200093, 3'd1, 64'h0, 8'h41);
    @(negedge clk); in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mrst_ready: got %b want 0", in_ready); end
    checks++; if (out_tag !== '0 || out_imm !== '0) begin errors++; $display("FAIL mrst_data: got tag %h imm %h want 0/0", out_tag, out_imm); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mrst_release: got ready %b valid %b want 1/0", in_ready, out_valid); end
    $display("reset midstream: out_valid=%b in_ready=%b", out_valid, in_ready);
  endtask

  initial begin
    test_reset();
    test_formats();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
